// File: rtl/pmp_access_ctrl_if.sv
// Bundle of the pipeline request/response, pmp and data-memory signals of
// the access sequencer. The controller takes the master modport (it drives
// pmp and memory and answers the pipeline); the environment takes slave.
interface pmp_access_ctrl_if #(
   parameter int CNT_W = 16
);
   // pipeline request
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_addr;
   logic [1:0]       req_size;
   logic [1:0]       req_oper;
   logic [1:0]       req_priv;
   logic [31:0]      req_wdata;
   // pmp
   logic [31:0]      addr;
   logic [1:0]       size;
   logic [1:0]       oper;
   logic [1:0]       priv_mode;
   logic [1:0]       permission;
   // data memory
   logic             mem_valid;
   logic             mem_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [1:0]       mem_size;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;
   // pipeline response
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_rdata;
   logic             rsp_fault;
   logic [3:0]       exc_cause;
   logic [31:0]      exc_tval;
   logic [CNT_W-1:0] fault_count;

   modport master (
      input  req_valid, req_addr, req_size, req_oper, req_priv, req_wdata,
             permission, mem_ready, mem_rdata, rsp_ready,
      output req_ready, addr, size, oper, priv_mode,
             mem_valid, mem_we, mem_addr, mem_size, mem_wdata,
             rsp_valid, rsp_rdata, rsp_fault, exc_cause, exc_tval, fault_count
   );

   modport slave (
      output req_valid, req_addr, req_size, req_oper, req_priv, req_wdata,
             permission, mem_ready, mem_rdata, rsp_ready,
      input  req_ready, addr, size, oper, priv_mode,
             mem_valid, mem_we, mem_addr, mem_size, mem_wdata,
             rsp_valid, rsp_rdata, rsp_fault, exc_cause, exc_tval, fault_count
   );
endinterface

// File: rtl/pmp_access_ctrl.sv
// Load/store/fetch sequencer in front of the pmp: one request at a time,
// pmp check, optional memory access with timeout, precise response.
module pmp_access_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   pmp_access_ctrl_if.master bus
);
   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_EXEC  = 2'd2;
   localparam logic [1:0] OP_RSV   = 2'd3;
   localparam logic [7:0] TO_LAST  = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CHECK, MEM, RESP} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [1:0]  oper;
      logic [1:0]  priv;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        fault;
      logic [3:0]  cause;
      logic [31:0] tval;
      logic [31:0] rdata;
   } rsp_t;

   state_t           state_q, state_d;
   req_t             req_q;
   rsp_t             rsp_q;
   logic             mem_we_q;
   logic [7:0]       to_cnt;
   logic [CNT_W-1:0] fault_cnt;
   logic             mis, chk_fault, mem_to, rsp_fire;
   logic [3:0]       chk_cause;

   // Access-fault cause by operation; the misaligned cause is always one less.
   function automatic logic [3:0] acc_cause(input logic [1:0] op);
      case (op)
         OP_EXEC:  acc_cause = 4'd1;
         OP_READ:  acc_cause = 4'd5;
         OP_WRITE: acc_cause = 4'd7;
         default:  acc_cause = 4'd2;
      endcase
   endfunction

   assign mis      = (req_q.size == 2'd1 && req_q.addr[0]) ||
                     (req_q.size == 2'd2 && req_q.addr[1:0] != 2'b00);
   assign mem_to   = (state_q == MEM) && !bus.mem_ready && (to_cnt == TO_LAST);
   assign rsp_fire = (state_q == RESP) && bus.rsp_ready;

   // CHECK-stage fault priority: misalign, then reserved encodings, then pmp.
   // A reserved oper has no misaligned cause, so it always reports illegal.
   always_comb begin
      chk_fault = 1'b1;
      chk_cause = 4'd0;
      if (mis && req_q.oper != OP_RSV)
         chk_cause = acc_cause(req_q.oper) - 4'd1;
      else if (req_q.size == 2'd3 || req_q.oper == OP_RSV)
         chk_cause = 4'd2;
      else if (bus.permission != 2'b11)
         chk_cause = acc_cause(req_q.oper);
      else
         chk_fault = 1'b0;
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.req_valid)                  state_d = CHECK;
         CHECK: state_d = chk_fault ? RESP : MEM;
         MEM:   if (bus.mem_ready || mem_to)        state_d = RESP;
         RESP:  if (bus.rsp_ready)                  state_d = IDLE;
         default:                                   state_d = IDLE;
      endcase
   end

   // Request capture on accept and response capture from CHECK / MEM.
   // A successful response carries tval=0 and cause=0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_q    <= '0;
         rsp_q    <= '0;
         mem_we_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               req_q    <= '{addr: bus.req_addr, size: bus.req_size, oper: bus.req_oper,
                             priv: bus.req_priv, wdata: bus.req_wdata};
               mem_we_q <= (bus.req_oper == OP_WRITE);
            end
            CHECK: if (chk_fault)
               rsp_q <= '{fault: 1'b1, cause: chk_cause, tval: req_q.addr, rdata: 32'd0};
            MEM: begin
               if (bus.mem_ready)
                  rsp_q <= '{fault: 1'b0, cause: 4'd0, tval: 32'd0,
                             rdata: mem_we_q ? 32'd0 : bus.mem_rdata};
               else if (mem_to)
                  rsp_q <= '{fault: 1'b1, cause: acc_cause(req_q.oper),
                             tval: req_q.addr, rdata: 32'd0};
            end
            default: ;
         endcase
      end
   end

   // Memory wait counter; cleared when the response is taken.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                to_cnt <= 8'd0;
      else if (rsp_fire)                         to_cnt <= 8'd0;
      else if (state_q == MEM && !bus.mem_ready) to_cnt <= to_cnt + 8'd1;
   end

   // Saturating count of faulted responses accepted by the pipeline.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         fault_cnt <= '0;
      else if (rsp_fire && rsp_q.fault && fault_cnt != {CNT_W{1'b1}})
         fault_cnt <= fault_cnt + 1'b1;
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.addr        = req_q.addr;
   assign bus.size        = req_q.size;
   assign bus.oper        = req_q.oper;
   assign bus.priv_mode   = req_q.priv;
   assign bus.mem_valid   = (state_q == MEM);
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = req_q.addr;
   assign bus.mem_size    = req_q.size;
   assign bus.mem_wdata   = req_q.wdata;
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.rsp_rdata   = rsp_q.rdata;
   assign bus.rsp_fault   = rsp_q.fault;
   assign bus.exc_cause   = rsp_q.cause;
   assign bus.exc_tval    = rsp_q.tval;
   assign bus.fault_count = fault_cnt;
endmodule

// File: tb/tb_pmp_access_ctrl.sv
// Directed bench for pmp_access_ctrl: scoreboard queue filled at issue,
// drained by a response monitor; pmp and memory are small behavioural models.
module tb_pmp_access_ctrl;
   localparam int CNT_W  = 4;
   localparam int FC_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic        fault;
      logic [3:0]  cause;
      logic [31:0] tval;
      logic [31:0] rdata;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   pmp_access_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pmp_access_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   int   exp_fc = 0;

   // memory model controls / observations
   int          mem_lat = 1;
   logic [31:0] mem_data = 32'h0;
   int          mcnt = 0;
   int          mem_cycles = 0;
   logic        last_we = 1'b0;
   logic [31:0] last_wdata = 32'h0;
   logic        pmp_w = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // pmp: entry0 TOR pmpaddr0=0x1000 covers bytes [0,0x4000), R=1, W=pmp_w, X=0
   always_comb begin
      bus.permission = 2'b00;
      if (bus.addr < 32'h4000 &&
          (bus.oper == 2'd0 || (bus.oper == 2'd1 && pmp_w)))
         bus.permission = 2'b11;
   end

   // memory: ready after mem_lat cycles of mem_valid, single-cycle pulse
   always @(negedge clock) begin
      if (bus.mem_valid) begin
         bus.mem_ready = (mcnt == mem_lat);
         bus.mem_rdata = mem_data;
         if (bus.mem_ready) begin
            last_we    = bus.mem_we;
            last_wdata = bus.mem_wdata;
         end
         mcnt++;
         mem_cycles++;
      end else begin
         bus.mem_ready = 1'b0;
         mcnt = 0;
      end
   end

   // response monitor
   always @(negedge clock) begin
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
         if (q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, e.fault});
            check("exc_cause", {28'd0, bus.exc_cause}, {28'd0, e.cause});
            check("exc_tval",  bus.exc_tval, e.tval);
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                        input logic [31:0] wd, input logic f, input logic [3:0] c,
                        input logic [31:0] rd);
      exp_t e;
      int   n;
      e.fault = f; e.cause = c; e.tval = f ? a : 32'd0; e.rdata = rd;
      q.push_back(e);
      if (f) exp_fc = (exp_fc == FC_MAX) ? FC_MAX : exp_fc + 1;
      n = 0;
      @(negedge clock);
      while (!bus.req_ready && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) check("req_ready_wait", 32'd0, 32'd1);
      bus.req_valid = 1'b1; bus.req_addr = a; bus.req_size = sz;
      bus.req_oper = op; bus.req_priv = 2'd3; bus.req_wdata = wd;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      mem_cycles = 0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clock); #1;
      while (!(q.size() == 0 && bus.req_ready) && n < 200) begin
         @(negedge clock); #1; n++;
      end
      if (n >= 200) check("rsp_wait", 32'd0, 32'd1);
   endtask

   task automatic run(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                      input logic [31:0] wd, input logic f, input logic [3:0] c,
                      input logic [31:0] rd, input int mcyc);
      issue(a, sz, op, wd, f, c, rd);
      wait_done();
      check("mem_cycles",  mem_cycles, mcyc);
      check("fault_count", {28'd0, bus.fault_count}, exp_fc);
   endtask

   initial begin
      int n;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_oper = '0;
      bus.req_priv = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      #1;
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_addr",      bus.addr, 32'd0);
      check("rst_fault_cnt", {28'd0, bus.fault_count}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // clean read, memory answers on the 2nd mem_valid cycle
      mem_lat = 1; mem_data = 32'hDEADBEEF;
      run(32'h800, 2'd2, 2'd0, 32'h0, 1'b0, 4'd0, 32'hDEADBEEF, 2);
      // denied write never reaches memory
      run(32'h800, 2'd2, 2'd1, 32'h1111, 1'b1, 4'd7, 32'h0, 0);
      // misalign wins over pmp permit / deny
      run(32'h801, 2'd1, 2'd0, 32'h0, 1'b1, 4'd4, 32'h0, 0);
      run(32'h802, 2'd2, 2'd2, 32'h0, 1'b1, 4'd0, 32'h0, 0);
      run(32'h803, 2'd2, 2'd1, 32'h0, 1'b1, 4'd6, 32'h0, 0);
      // reserved size / oper
      run(32'h800, 2'd3, 2'd0, 32'h0, 1'b1, 4'd2, 32'h0, 0);
      run(32'h800, 2'd2, 2'd3, 32'h0, 1'b1, 4'd2, 32'h0, 0);
      // pmp denials: exec (X=0), read outside region
      run(32'h800,  2'd2, 2'd2, 32'h0, 1'b1, 4'd1, 32'h0, 0);
      run(32'h5000, 2'd0, 2'd0, 32'h0, 1'b1, 4'd5, 32'h0, 0);
      // memory timeout after 16 cycles, then ready on exactly cycle 16
      mem_lat = 99;
      run(32'h900, 2'd2, 2'd0, 32'h0, 1'b1, 4'd5, 32'h0, 16);
      mem_lat = 15; mem_data = 32'h12345678;
      run(32'h904, 2'd2, 2'd0, 32'h0, 1'b0, 4'd0, 32'h12345678, 16);
      // permitted write: rdata 0, memory sees we/wdata
      pmp_w = 1'b1; mem_lat = 0; mem_data = 32'hFFFFFFFF;
      run(32'hC00, 2'd2, 2'd1, 32'hA5A5_5A5A, 1'b0, 4'd0, 32'h0, 1);
      check("mem_we",    {31'd0, last_we}, 32'd1);
      check("mem_wdata", last_wdata, 32'hA5A5_5A5A);
      pmp_w = 1'b0;

      // response back-pressure: outputs hold, no new request accepted
      bus.rsp_ready = 1'b0; mem_lat = 0; mem_data = 32'hCAFEF00D;
      issue(32'h804, 2'd2, 2'd0, 32'h0, 1'b0, 4'd0, 32'hCAFEF00D);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin @(negedge clock); n++; end
      if (n >= 50) check("stall_rsp_wait", 32'd0, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
         check("stall_rdata",     bus.rsp_rdata, 32'hCAFEF00D);
         check("stall_fault",     {31'd0, bus.rsp_fault}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
      wait_done();

      // saturate the fault counter
      for (int i = 0; i < FC_MAX + 4; i++)
         run(32'h800, 2'd2, 2'd1, 32'h0, 1'b1, 4'd7, 32'h0, 0);
      check("fault_sat", {28'd0, bus.fault_count}, FC_MAX);

      // reset during MEM drops the request immediately
      mem_lat = 99;
      issue(32'h808, 2'd2, 2'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      n = 0;
      while (!bus.mem_valid && n < 20) begin @(negedge clock); n++; end
      if (n >= 20) check("mem_valid_wait", 32'd0, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("rr_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      check("rr_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rr_fault_cnt", {28'd0, bus.fault_count}, 32'd0);
      q.delete(); exp_fc = 0;
      mem_lat = 1; mem_data = 32'h0BAD_F00D;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("post_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      end
      run(32'h80C, 2'd2, 2'd0, 32'h0, 1'b0, 4'd0, 32'h0BAD_F00D, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pmp_access_ctrl.md
Name: pmp_access_ctrl

Overview:
- Load/store/fetch access sequencer sitting directly upstream of the pmp block.
- Accepts one memory request at a time from the pipeline and drives addr/size/oper/priv_mode into pmp.
- Samples the pmp permission result and, if allowed, issues the access to data memory with a valid/ready handshake.
- Returns data or a precise exception (cause, tval) to the pipeline; faulted accesses never reach memory.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before declaring an access fault (1..255).
- CNT_W, 16, width of the saturating fault counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_oper  in  2  0=READ, 1=WRITE, 2=EXEC, 3=reserved
- req_priv  in  2  privilege mode, forwarded to pmp
- req_wdata  in  32  store data
- addr  out  32  to pmp, registered copy of req_addr
- size  out  2  to pmp
- oper  out  2  to pmp
- priv_mode  out  2  to pmp
- permission  in  2  from pmp: 2'b11 = allowed, otherwise denied
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepted/completed (read data valid same cycle)
- mem_we  out  1  write enable (oper==WRITE)
- mem_addr  out  32  memory address
- mem_size  out  2  memory size
- mem_wdata  out  32  memory store data
- mem_rdata  in  32  memory read data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  32  load/fetch data (0 on fault or write)
- rsp_fault  out  1  response carries exception
- exc_cause  out  4  RISC-V mcause code
- exc_tval  out  32  faulting address
- fault_count  out  CNT_W  saturating count of faulted responses

Behaviour:
- Reset (reset=0, async): state=IDLE; req_ready=1; mem_valid=0; rsp_valid=0; rsp_fault=0; addr/size/oper/priv_mode/mem_*/rsp_rdata/exc_cause/exc_tval=0; fault_count=0; timeout counter=0.
- IDLE: req_ready=1. On req_valid&&req_ready, register the request into the pmp outputs and mem_*, then go to CHECK. req_ready=0 in every other state.
- CHECK (1 cycle, pmp is combinational): evaluate in priority order, first match wins:
  1. Misaligned (size1 & addr[0]!=0, or size2 & addr[1:0]!=0): cause 0 (EXEC) / 4 (READ) / 6 (WRITE).
  2. size==3 or oper==3: cause 2.
  3. permission!=2'b11: cause 1 (EXEC) / 5 (READ) / 7 (WRITE).
  4. Otherwise go to MEM.
  - Any fault: go to RESP with rsp_fault=1, exc_tval=addr, rsp_rdata=0.
- MEM: mem_valid=1 and mem_* held stable until mem_ready.
  - mem_ready=1: latch mem_rdata (0 for writes) into rsp_rdata; go to RESP with rsp_fault=0.
  - Timeout counter increments each MEM cycle without mem_ready. Reaching MEM_TIMEOUT: drop mem_valid, go to RESP with an access fault (cause 1/5/7, tval=addr).
  - mem_ready in the same cycle the counter hits MEM_TIMEOUT counts as success.
- RESP: rsp_valid=1; all rsp_*/exc_* held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE and clear the timeout counter. rsp_ready asserted before rsp_valid is ignored.
- Latency: clean access = 1 (accept) + 1 (CHECK) + n (memory) + 1 (RESP) cycles minimum; a faulted access reaches RESP the cycle after CHECK.
- fault_count increments by 1 on each accepted faulted response handshake and saturates at all-ones.
- Stable-input rule: pmp outputs stay constant from acceptance until the return to IDLE, so a concurrent pmp CSR write changes the permission sampled in CHECK only.
- Reset asserted mid-operation: immediate return to reset values; no mem_valid glitch after reset release; the in-flight request is dropped.
- exc_cause=0 when rsp_fault=0.

Test Plan:
- pmp with entry0 TOR pmpaddr0=0x1000 R=1 W=0; READ word at 0x0000_0800, mem_ready after 2 cycles with rdata 0xDEADBEEF -> rsp_valid, rsp_fault=0, rsp_rdata=0xDEADBEEF; req_ready returns 1 after handshake.
- Same config, WRITE word at 0x800 -> no mem_valid ever, rsp_fault=1, exc_cause=7, exc_tval=0x800, fault_count=1.
- READ half at 0x801 -> exc_cause=4 even though pmp permits (misalign priority); EXEC word at 0x802 -> exc_cause=0.
- Permitted READ with mem_ready held low, MEM_TIMEOUT=16 -> mem_valid drops after 16 cycles, exc_cause=5; repeat with mem_ready arriving on cycle 16 -> success.
- Hold rsp_ready=0 for 5 cycles -> rsp outputs stable, req_ready=0; drive 2^CNT_W+3 faults -> fault_count saturates at 0xFFFF.
- Assert reset during MEM -> mem_valid=0 and state IDLE immediately; a new request after release completes normally.
